mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Multi-cycle load/store unit feeding the write-back stage via mem_wen_o/mem_wdata_o.
//  Accepts one access per start_i pulse, drives a 64-bit req/gnt/rvalid data bus with byte strobes,
//  aligns and sign/zero-extends load data. Holds the result stable until the next access.
// PARAMETERS
//  ADDR_W   64   byte-address width; the bus address is always 8-byte aligned
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-high
//  start_i      in   1       1-cycle access request from the instruction-cycle controller
//  is_load_i    in   1       access is a load
//  is_store_i   in   1       access is a store (is_load_i and is_store_i both high = illegal, treated as no-op)
//  funct3_i     in   3       RV64 width/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  rd_wen_i     in   1       load result is written to rd
//  addr_i       in   ADDR_W  effective byte address
//  wdata_i      in   64      store data, right-justified
//  bus_req_o    out  1       bus request
//  bus_we_o     out  1       1 = write
//  bus_addr_o   out  ADDR_W  {addr[ADDR_W-1:3], 3'b0}
//  bus_wdata_o  out  64      store data shifted to the byte lane
//  bus_wstrb_o  out  8       byte enables
//  bus_gnt_i    in   1       request accepted (writes complete at gnt)
//  bus_rvalid_i in   1       read data valid
//  bus_rdata_i  in   64      read data, full aligned doubleword
//  mem_wen_o    out  1       write-back enable toward the WB stage
//  mem_wdata_o  out  64      extended load result
//  done_o       out  1       1-cycle pulse when the access finishes
//  busy_o       out  1       state != IDLE
//  misalign_o   out  1       misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; every output 0. Reset asserted mid-access drops bus_req_o at once,
//   discards any latched operands, and ignores a later bus_rvalid_i.
//  FSM IDLE/REQ/WAIT/DONE:
//   IDLE: start_i with a valid load or store latches all operands -> REQ. Clears mem_wen_o/mem_wdata_o next cycle.
//         start_i with neither, an illegal op, or reserved funct3 (load 111, store 1xx) -> DONE, no bus access.
//   REQ:  bus_req_o=1; addr/we/wdata/wstrb come from latched regs and are stable until gnt.
//         On gnt, a store goes to DONE and a load goes to WAIT.
//   WAIT: bus_req_o=0. On bus_rvalid_i, capture the extracted data -> DONE. Any rvalid outside WAIT is ignored.
//   DONE: done_o=1 for one cycle. mem_wen_o <= is_load & rd_wen & no error. -> IDLE.
//  start_i outside IDLE is ignored.
//  Latency with gnt in the first REQ cycle and rvalid N cycles later: load done at start+2+N; store done at start+2.
//  mem_wen_o and mem_wdata_o are registered. They stay set from DONE until the cycle after the next accepted start_i.
//  Load extraction, with off = addr[2:0]: the field is rdata >> (off*8).
//   B/H/W sign-extend bit 7/15/31; BU/HU/WU zero-extend; D uses all 64 bits.
//  Store: wstrb = {1,3,15,255}[size] << off; bus_wdata = wdata_i << (off*8), bits above size zeroed before shifting.
//  Accesses crossing the 8-byte boundary cannot occur: misaligned accesses are trapped or masked (see below).
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//   An address not a multiple of the access size -> no bus access, DONE next cycle, misalign_o=1 in DONE, mem_wen_o=0.
//  MEM_MISALIGN_CHECK_EN undefined:
//   misalign_o tied 0; offset low bits below the size are forced to 0 (access aligned down).
// TESTING
//  1 LD addr 0x8000_0010, gnt immediate, rvalid 2 cycles later with 0x1122334455667788
//    -> bus_addr 0x8000_0010, wstrb 0; done at start+4; mem_wdata_o=0x1122334455667788, mem_wen_o=1 held.
//  2 LB addr 0x8000_0013, rdata 0x0000_0000_8000_0000 -> 0xFFFF_FFFF_FFFF_FF80.
//    Same with LBU -> 0x80. LHU at 0x..12 -> 0x8000.
//  3 SH addr 0x8000_0006, wdata 0x1234_BEEF -> bus_addr 0x8000_0000, wstrb 0xC0,
//    bus_wdata[63:48]=0xBEEF, other bytes 0, bus_we 1; done at start+2; mem_wen_o=0.
//  4 gnt delayed 3 cycles; second start_i pulse while busy -> req/addr stable all 3 cycles; second start ignored; one done pulse.
//  5 rst pulse during WAIT, then rvalid -> all outputs 0 immediately, state IDLE, no done_o, mem_wen_o stays 0.
//  6 LW addr 0x8000_0002 -> with macro: misalign_o=1, no bus_req_o, done at start+2, mem_wen_o=0;
//    without macro: bus_addr 0x8000_0000, word at offset 0 returned.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: multi-cycle load/store unit between execute and write-back.
// Accepts one access per start_i pulse and runs it on a 64-bit req/gnt/rvalid bus
// with byte strobes. Load data is aligned and sign/zero-extended into mem_wdata_o,
// which is held together with mem_wen_o until the next accepted access.
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned accesses skip the bus and finish with misalign_o=1
//   undefined : misalign_o is tied 0 and the offset is aligned down to the size
module mem_access_stage #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic              rd_wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       wdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [63:0]       bus_wdata_o,
    output logic [7:0]        bus_wstrb_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [63:0]       bus_rdata_i,
    output logic              mem_wen_o,
    output logic [63:0]       mem_wdata_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              misalign_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_reg;
    logic              is_load_reg;
    logic              rd_wen_reg;
    logic [2:0]        funct3_reg;
    logic [2:0]        off_reg;
    logic [ADDR_W-4:0] addr_reg;
    logic [63:0]       wdata_reg;
    logic [7:0]        wstrb_reg;
    logic              err_reg;
    logic              mem_wen_reg;
    logic [63:0]       mem_wdata_reg;

    // Decode of the incoming request (only meaningful in IDLE with start_i)
    logic        op_valid;
    logic        op_mis;
    logic [2:0]  low_mask;
    logic [2:0]  off_next;
    logic [7:0]  wstrb_next;
    logic [63:0] wdata_sized;
    logic [63:0] wdata_next;

    // Load extraction from the returned doubleword
    logic [63:0] rd_shifted;
    logic [63:0] load_ext;

    // Size mask, legality, byte-lane placement of store data and strobes
    always_comb begin
        low_mask    = 3'b000;
        wstrb_next  = 8'h00;
        wdata_sized = 64'd0;
        case (funct3_i[1:0])
            2'd0: begin low_mask = 3'b000; wdata_sized = {56'd0, wdata_i[7:0]};  end
            2'd1: begin low_mask = 3'b001; wdata_sized = {48'd0, wdata_i[15:0]}; end
            2'd2: begin low_mask = 3'b011; wdata_sized = {32'd0, wdata_i[31:0]}; end
            default: begin low_mask = 3'b111; wdata_sized = wdata_i; end
        endcase
        op_valid = (is_load_i ^ is_store_i) &&
                   (is_load_i ? (funct3_i != 3'b111) : !funct3_i[2]);
`ifdef MEM_MISALIGN_CHECK_EN
        op_mis   = |(addr_i[2:0] & low_mask);
        off_next = addr_i[2:0];
`else
        op_mis   = 1'b0;
        off_next = addr_i[2:0] & ~low_mask;
`endif
        case (funct3_i[1:0])
            2'd0:    wstrb_next = 8'h01 << off_next;
            2'd1:    wstrb_next = 8'h03 << off_next;
            2'd2:    wstrb_next = 8'h0F << off_next;
            default: wstrb_next = 8'hFF;
        endcase
        wdata_next = wdata_sized << {off_next, 3'b000};
    end

    // Align returned data to bit 0 and extend according to the latched width
    always_comb begin
        rd_shifted = bus_rdata_i >> {off_reg, 3'b000};
        case (funct3_reg)
            3'b000:  load_ext = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            3'b001:  load_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  load_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            3'b100:  load_ext = {56'd0, rd_shifted[7:0]};
            3'b101:  load_ext = {48'd0, rd_shifted[15:0]};
            3'b110:  load_ext = {32'd0, rd_shifted[31:0]};
            default: load_ext = rd_shifted;
        endcase
    end

    // Access FSM, operand latches and write-back result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            is_load_reg   <= 1'b0;
            rd_wen_reg    <= 1'b0;
            funct3_reg    <= 3'd0;
            off_reg       <= 3'd0;
            addr_reg      <= '0;
            wdata_reg     <= 64'd0;
            wstrb_reg     <= 8'd0;
            err_reg       <= 1'b0;
            mem_wen_reg   <= 1'b0;
            mem_wdata_reg <= 64'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        is_load_reg   <= is_load_i && op_valid;
                        rd_wen_reg    <= rd_wen_i;
                        funct3_reg    <= funct3_i;
                        off_reg       <= off_next;
                        addr_reg      <= addr_i[ADDR_W-1:3];
                        wdata_reg     <= is_store_i ? wdata_next : 64'd0;
                        wstrb_reg     <= is_store_i ? wstrb_next : 8'd0;
                        err_reg       <= op_valid && op_mis;
                        mem_wen_reg   <= 1'b0;
                        mem_wdata_reg <= 64'd0;
                        state_reg     <= op_valid ? S_REQ : S_DONE;
                    end
                end
                S_REQ: begin
                    // A trapped misaligned access spends this cycle off the bus
                    if (err_reg) begin
                        state_reg <= S_DONE;
                    end else if (bus_gnt_i) begin
                        state_reg <= is_load_reg ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    if (bus_rvalid_i) begin
                        mem_wdata_reg <= load_ext;
                        mem_wen_reg   <= rd_wen_reg;
                        state_reg     <= S_DONE;
                    end
                end
                default: begin
                    err_reg   <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Bus signals are only driven while a request is actually outstanding
    always_comb begin
        bus_req_o   = (state_reg == S_REQ) && !err_reg;
        bus_we_o    = bus_req_o && !is_load_reg;
        bus_addr_o  = bus_req_o ? {addr_reg, 3'b000} : '0;
        bus_wdata_o = bus_req_o ? wdata_reg : 64'd0;
        bus_wstrb_o = bus_req_o ? wstrb_reg : 8'd0;
        done_o      = (state_reg == S_DONE);
        busy_o      = (state_reg != S_IDLE);
        mem_wen_o   = mem_wen_reg;
        mem_wdata_o = mem_wdata_reg;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_o  = done_o && err_reg;
`else
        misalign_o  = 1'b0;
`endif
    end

endmodule
